io_uart_responder: RTL and testbench
====================================

Name: io_uart_responder

Overview:
- Memory-mapped UART peripheral that is the responder on the CPU IO bus.
- Decodes CPU io_rd/io_wr strobes, returns read data combinationally on io_din in the strobe cycle, and drives a level interrupt_request back to the CPU.
- Contains a TX FIFO with serializer and an RX deserializer with RX FIFO; serial format fixed 8N1.

Parameters:
SEL_BIT, 12, io_addr bit that selects this peripheral (selected when io_addr[SEL_BIT]=1)
FIFOBITS, 3, FIFO depth 2**FIFOBITS entries, each for TX and RX
DEFAULT_DIV, 217, reset value of baud divisor (clocks per bit)

Ports:
clk  input  1  clock
resetq  input  1  asynchronous active-low reset
io_rd  input  1  CPU read strobe, one cycle
io_wr  input  1  CPU write strobe, one cycle
io_addr  input  32  CPU address; register offset io_addr[3:2]
io_dout  input  32  CPU write data
io_din  output  32  read data to CPU, combinational
interrupt_request  output  1  level interrupt to CPU
uart_rx  input  1  serial in, asynchronous
uart_tx  output  1  serial out, idle high

Behaviour:
- Reset (async, resetq=0): uart_tx=1, interrupt_request=0, both FIFOs empty, sticky flags 0, ie=0, div=DEFAULT_DIV, TX/RX FSMs IDLE. Applies immediately even mid-frame.
- sel = io_addr[SEL_BIT]. io_din = 0 whenever sel=0 or io_rd=0, so CPU-side OR-ing of peripherals is safe.
- Offset 0 DATA: write pushes io_dout[7:0] to TX FIFO; a write when full is dropped. Read returns {24'b0, RX head} and pops on that edge; a read when empty returns 0 with no pop.
- Offset 1 STATUS, read {27'b0, ferr, ovr, tx_idle, rx_avail, tx_notfull}. tx_idle = TX FIFO empty and serializer IDLE. A write with io_dout[3]=1 clears ovr and io_dout[4]=1 clears ferr (write-1-to-clear); other bits are ignored.
- Offset 2 DIV: read/write, 16 bits in io_dout[15:0]. Read returns {16'b0, div}. Values below 4 are clamped to 4. TX and RX latch div at frame start; a change mid-frame applies to the next frame.
- Offset 3 IE: read/write {29'b0, ie[2:0]}.
- interrupt_request = registered OR of (ie0 & rx_avail) | (ie1 & tx_notfull) | (ie2 & (ovr|ferr)). One cycle latency after the condition changes.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, or directly to START if the FIFO is non-empty.
  - Each bit is held exactly div clocks.
  - From IDLE, uart_tx falls on the 2nd rising edge after the io_wr edge that pushed into an empty FIFO.
  - Back-to-back frames have no idle gap.
- RX FSM:
  - Input passes a 2-flop synchronizer.
  - IDLE: a falling edge enters START. At div/2 (integer) the line is rechecked; if high, it is a false start and returns to IDLE.
  - DATA: sample at div/2 + k*div, k=1..8.
  - STOP: sample at div/2 + 9*div.
    - Stop=1: push byte, or drop it and set ovr if the FIFO is full.
    - Stop=0: set ferr, discard byte, wait for line high, then IDLE.
- FIFOs: simultaneous push and pop in one cycle are both performed, and the count is unchanged. A pop while full followed by a push in the same cycle is legal. Pointers wrap modulo 2**FIFOBITS.
- Accesses with sel=0 have no side effects.

Test Plan:
- Reset with uart_tx idle, read STATUS (addr 0x1004) -> io_din=0x00000005, interrupt_request=0, DIV read = 217.
- Write DIV=8, write DATA 0xA5 -> uart_tx: start 8 clk low, bits 1,0,1,0,0,1,0,1 for 8 clk each, stop 8 clk high; tx_idle=1 afterwards.
- Write 9 bytes 0x01..0x09 back-to-back into an 8-deep FIFO with DIV=8 and the serializer idle. Expect 0x01 to be loaded into the serializer, 0x02..0x09 to all be accepted, and no frames to be lost or gapped.
- Drive 0x3C on uart_rx at DIV=8 with ie=1 -> rx_avail=1, interrupt_request rises, DATA read = 0x3C, the next DATA read = 0, interrupt_request drops.
- Drive 9 valid frames without reading -> ovr=1; STATUS write 0x08 clears ovr; the 8 stored bytes read back in order.
- Drive a frame with stop bit 0 -> ferr=1, no push. Drive a 2-clk low glitch -> no frame and no flags. Assert resetq mid-TX frame -> uart_tx=1 at once and the FIFO is empty.

Source files
------------

// File: rtl/io_uart_responder.sv
// io_uart_responder: memory-mapped 8N1 UART responder on the CPU IO bus with TX/RX FIFOs and a level interrupt
module io_uart_fifo #(
  parameter int B = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam logic [B-1:0] ONE = 1;
  logic [7:0] mem [2**B];
  logic [B-1:0] wp, rp;
  logic [B:0] cnt;
  logic do_push, do_pop;
  assign empty = cnt == '0;
  assign full = cnt[B];
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + ONE;
      if (do_pop) rp <= rp + ONE;
      cnt <= cnt + {{B{1'b0}}, do_push} - {{B{1'b0}}, do_pop};
    end
endmodule

module io_uart_responder #(
  parameter int SEL_BIT = 12,
  parameter int FIFOBITS = 3,
  parameter int DEFAULT_DIV = 217
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic        interrupt_request,
  input  logic        uart_rx,
  output logic        uart_tx
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  logic sel;
  logic [1:0] off;
  logic wr_data, rd_data, wr_stat, wr_div, wr_ie;
  logic [15:0] div;
  logic [2:0] ie;
  logic ovr, ferr, ovr_set;
  logic tx_empty, tx_full, tx_idle;
  logic [7:0] tx_head;
  logic rx_empty, rx_full;
  logic [7:0] rx_head;
  logic unused_ok;
  assign unused_ok = ^{io_addr, io_dout};
  assign sel = io_addr[SEL_BIT];
  assign off = io_addr[3:2];
  assign wr_data = io_wr & sel & (off == 2'd0);
  assign rd_data = io_rd & sel & (off == 2'd0);
  assign wr_stat = io_wr & sel & (off == 2'd1);
  assign wr_div = io_wr & sel & (off == 2'd2);
  assign wr_ie = io_wr & sel & (off == 2'd3);
  // Serializer: uart_tx is registered from the current state, so every bit is shifted one clock late but held exactly div clocks
  tx_state_t tx_state, tx_next;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic tx_tick, tx_load;
  assign tx_tick = tx_cnt == 16'd0;
  assign tx_idle = tx_empty & (tx_state == TX_IDLE);
  always_comb begin
    tx_load = !tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_tick));
    tx_next = tx_load ? TX_START :
              !tx_tick ? tx_state :
              tx_state == TX_START ? TX_DATA :
              tx_state == TX_DATA ? (tx_bit == 3'd7 ? TX_STOP : TX_DATA) : TX_IDLE;
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) tx_state <= TX_IDLE;
    else tx_state <= tx_next;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      uart_tx <= 1'b1;
      tx_cnt <= '0;
      tx_div <= 16'(DEFAULT_DIV);
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      uart_tx <= tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : 1'b1;
      if (tx_load) begin
        tx_sh <= tx_head;
        tx_div <= div;
        tx_cnt <= div - 16'd1;
        tx_bit <= '0;
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_tick ? tx_div - 16'd1 : tx_cnt - 16'd1;
        if (tx_tick & (tx_state == TX_DATA)) begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 3'd1;
        end
      end
    end
  io_uart_fifo #(.B(FIFOBITS)) u_tx_fifo (
    .clk(clk), .resetq(resetq), .push(wr_data), .pop(tx_load),
    .din(io_dout[7:0]), .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );
  // Deserializer: counter is preloaded with div/2-1 while idle so the start recheck lands mid-bit
  rx_state_t rx_state, rx_next;
  logic rx_s1, rx_s2, rx_d;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic rx_tick, rx_done, rx_bad;
  assign rx_tick = rx_cnt == 16'd0;
  always_comb begin
    rx_done = (rx_state == RX_STOP) & rx_tick & rx_s2;
    rx_bad = (rx_state == RX_STOP) & rx_tick & !rx_s2;
    rx_next = rx_state == RX_IDLE ? (rx_d & !rx_s2 ? RX_START : RX_IDLE) :
              rx_state == RX_BREAK ? (rx_s2 ? RX_IDLE : RX_BREAK) :
              !rx_tick ? rx_state :
              rx_state == RX_START ? (rx_s2 ? RX_IDLE : RX_DATA) :
              rx_state == RX_DATA ? (rx_bit == 3'd7 ? RX_STOP : RX_DATA) :
              rx_s2 ? RX_IDLE : RX_BREAK;
  end
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) rx_state <= RX_IDLE;
    else rx_state <= rx_next;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d <= 1'b1;
      rx_cnt <= '0;
      rx_div <= 16'(DEFAULT_DIV);
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d <= rx_s2;
      if (rx_state == RX_IDLE) begin
        rx_div <= div;
        rx_cnt <= {1'b0, div[15:1]} - 16'd1;
        rx_bit <= '0;
      end else begin
        rx_cnt <= rx_tick ? rx_div - 16'd1 : rx_cnt - 16'd1;
        if (rx_tick & (rx_state == RX_DATA)) begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
        end
      end
    end
  io_uart_fifo #(.B(FIFOBITS)) u_rx_fifo (
    .clk(clk), .resetq(resetq), .push(rx_done), .pop(rd_data),
    .din(rx_sh), .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );
  // A read in the same cycle frees a slot, so a full FIFO only overflows without one
  assign ovr_set = rx_done & rx_full & !rd_data;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      div <= 16'(DEFAULT_DIV);
      ie <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      interrupt_request <= 1'b0;
    end else begin
      if (wr_div) div <= io_dout[15:0] < 16'd4 ? 16'd4 : io_dout[15:0];
      if (wr_ie) ie <= io_dout[2:0];
      ovr <= ovr_set | (ovr & !(wr_stat & io_dout[3]));
      ferr <= rx_bad | (ferr & !(wr_stat & io_dout[4]));
      interrupt_request <= |(ie & {ovr | ferr, !tx_full, !rx_empty});
    end
  assign io_din = !(sel & io_rd) ? '0 :
                  off == 2'd0 ? {24'b0, rx_empty ? 8'h00 : rx_head} :
                  off == 2'd1 ? {27'b0, ferr, ovr, tx_idle, !rx_empty, !tx_full} :
                  off == 2'd2 ? {16'b0, div} : {29'b0, ie};
endmodule

// File: tb/tb_io_uart_responder.sv
// tb_io_uart_responder: register vectors plus TX/RX scoreboards for the UART responder
module tb_io_uart_responder;
  logic clk = 0, resetq = 0, io_rd = 0, io_wr = 0, uart_rx = 1;
  logic [31:0] io_addr = 0, io_dout = 0;
  logic [31:0] io_din;
  logic interrupt_request, uart_tx;
  int n_tests = 0, n_fail = 0, tb_div = 217, cyc = 0, burst_n = 0, prev_start = 0;
  bit mon_en = 1, btb_chk = 0;
  logic [7:0] tx_q[$], rx_q[$];
  localparam logic [31:0] A_DATA = 32'h1000, A_STAT = 32'h1004, A_DIV = 32'h1008, A_IE = 32'h100C;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string name;
  } vec_t;
  vec_t v[$];

  io_uart_responder dut (
    .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
    .io_dout(io_dout), .io_din(io_din), .interrupt_request(interrupt_request),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One bus cycle starting at a negedge; io_din is captured 1 unit later
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data, output logic [31:0] rd);
    io_wr = wr;
    io_rd = !wr;
    io_addr = addr;
    io_dout = data;
    #1 rd = io_din;
    @(negedge clk);
    io_wr = 0;
    io_rd = 0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] r;
    access(0, addr, 0, r);
    check(name, r, exp);
  endtask

  task automatic wait_tx_idle(input string name, input int maxc);
    logic [31:0] r;
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      access(0, A_STAT, 0, r);
      ok = r[2];
    end
    check(name, {31'b0, ok}, 1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    uart_rx = 0;
    repeat (tb_div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (tb_div) @(negedge clk);
    end
    uart_rx = stop;
    repeat (tb_div) @(negedge clk);
    uart_rx = 1;
  endtask

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      #1;
      if (mon_en && resetq) begin
        if (btb_chk && burst_n > 0) check("tx_gap", cyc - prev_start, 10 * tb_div);
        prev_start = cyc;
        burst_n++;
        repeat (tb_div / 2) @(negedge clk);
        check("tx_start_bit", {31'b0, uart_tx}, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (tb_div) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (tb_div) @(negedge clk);
        check("tx_stop_bit", {31'b0, uart_tx}, 1);
        if (tx_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL tx_extra_frame: got byte 0x%0h with none expected", b);
        end else check("tx_byte", {24'b0, b}, {24'b0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] r;
    int n;
    v.push_back('{0, A_STAT, 0, 5, "status_rst"});
    v.push_back('{0, A_DIV, 0, 217, "div_rst"});
    v.push_back('{0, A_IE, 0, 0, "ie_rst"});
    v.push_back('{0, A_DATA, 0, 0, "data_empty"});
    v.push_back('{1, A_DIV, 2, 0, "wr_div_lo"});
    v.push_back('{0, A_DIV, 0, 4, "div_clamp"});
    v.push_back('{1, A_DIV, 32'h12345, 0, "wr_div_wide"});
    v.push_back('{0, A_DIV, 0, 32'h2345, "div_16b"});
    v.push_back('{1, A_IE, 32'hFF, 0, "wr_ie"});
    v.push_back('{0, A_IE, 0, 7, "ie_mask"});
    v.push_back('{1, A_IE, 0, 0, "wr_ie0"});
    v.push_back('{0, 32'h0004, 0, 0, "unsel_rd"});
    v.push_back('{1, 32'h0008, 9, 0, "unsel_wr_div"});
    v.push_back('{1, 32'h0000, 32'h55, 0, "unsel_wr_data"});
    v.push_back('{0, A_STAT, 0, 5, "unsel_no_push"});
    v.push_back('{0, A_DIV, 0, 32'h2345, "unsel_div_kept"});
    v.push_back('{1, A_STAT, 32'h18, 0, "wr_stat_w1c"});
    v.push_back('{0, A_STAT, 0, 5, "stat_after_w1c"});
    v.push_back('{1, A_DIV, 8, 0, "wr_div8"});
    v.push_back('{0, A_DIV, 0, 8, "div8"});

    repeat (3) @(negedge clk);
    check("tx_in_reset", {31'b0, uart_tx}, 1);
    resetq = 1;
    @(negedge clk);
    check("irq_rst", {31'b0, interrupt_request}, 0);
    foreach (v[i]) begin
      access(v[i].wr, v[i].addr, v[i].data, r);
      check(v[i].name, r, v[i].exp);
    end
    tb_div = 8;

    // interrupt latency on tx_notfull
    access(1, A_IE, 2, r);
    check("irq_lat0", {31'b0, interrupt_request}, 0);
    @(negedge clk);
    check("irq_tx_notfull", {31'b0, interrupt_request}, 1);
    access(1, A_IE, 0, r);
    @(negedge clk);
    check("irq_off", {31'b0, interrupt_request}, 0);

    // single frame 0xA5 with start latency and start-bit length
    tx_q.push_back(8'hA5);
    access(1, A_DATA, 32'hA5, r);
    check("tx_lat_e1", {31'b0, uart_tx}, 1);
    @(negedge clk);
    check("tx_lat_e2", {31'b0, uart_tx}, 1);
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40 && uart_tx === 1'b0; i++) begin
      n++;
      @(negedge clk);
    end
    check("tx_start_len", n, 8);
    wait_tx_idle("tx_idle_a5", 200);

    // nine back-to-back writes, then one dropped while full
    btb_chk = 1;
    burst_n = 0;
    for (int b = 1; b <= 9; b++) begin
      tx_q.push_back(8'(b));
      access(1, A_DATA, b, r);
    end
    rd_chk("tx_full_status", A_STAT, 0);
    access(1, A_DATA, 32'hEE, r);
    wait_tx_idle("tx_idle_burst", 900);
    btb_chk = 0;
    check("tx_burst_frames", burst_n, 9);

    // RX single byte with rx_avail interrupt
    access(1, A_IE, 1, r);
    rx_q.push_back(8'h3C);
    send_frame(8'h3C, 1);
    check("irq_rx", {31'b0, interrupt_request}, 1);
    rd_chk("rx_avail", A_STAT, 7);
    access(0, A_DATA, 0, r);
    check("rx_3c", r, {24'b0, rx_q.pop_front()});
    rd_chk("rx_empty_rd", A_DATA, 0);
    check("irq_rx_drop", {31'b0, interrupt_request}, 0);

    // overflow on the ninth unread frame
    access(1, A_IE, 4, r);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) rx_q.push_back(8'(8'h11 * i + 3));
      send_frame(8'(8'h11 * i + 3), 1);
    end
    check("irq_ovr", {31'b0, interrupt_request}, 1);
    rd_chk("ovr_set", A_STAT, 32'h0F);
    access(1, A_STAT, 32'h08, r);
    rd_chk("ovr_clr", A_STAT, 7);
    check("irq_ovr_clr", {31'b0, interrupt_request}, 0);
    for (int i = 0; i < 8; i++) begin
      access(0, A_DATA, 0, r);
      check("rx_fifo_order", r, {24'b0, rx_q.pop_front()});
    end
    rd_chk("rx_drained", A_STAT, 5);

    // framing error, then glitch rejection, then recovery
    access(1, A_IE, 0, r);
    send_frame(8'h5A, 0);
    rd_chk("ferr_set", A_STAT, 32'h15);
    access(1, A_STAT, 32'h10, r);
    rd_chk("ferr_clr", A_STAT, 5);
    uart_rx = 0;
    repeat (2) @(negedge clk);
    uart_rx = 1;
    repeat (20) @(negedge clk);
    rd_chk("glitch_ignored", A_STAT, 5);
    rx_q.push_back(8'h81);
    send_frame(8'h81, 1);
    access(0, A_DATA, 0, r);
    check("rx_after_glitch", r, {24'b0, rx_q.pop_front()});

    // asynchronous reset in the middle of a TX frame
    mon_en = 0;
    for (int i = 0; i < 3; i++) access(1, A_DATA, 0, r);
    repeat (20) @(negedge clk);
    check("tx_mid_frame", {31'b0, uart_tx}, 0);
    resetq = 0;
    #1 check("tx_async_rst", {31'b0, uart_tx}, 1);
    @(negedge clk);
    resetq = 1;
    rd_chk("fifo_empty_after_rst", A_STAT, 5);
    rd_chk("div_after_rst", A_DIV, 217);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) n++;
    end
    check("tx_quiet_after_rst", n, 0);

    check("tx_q_drained", tx_q.size(), 0);
    check("rx_q_drained", rx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
